// File: rtl/usbf_dma_sched.sv
// ---------------------------------------------------------------------------
// usbf_dma_sched
//   Round-robin scheduler sharing one external DMA channel between the
//   function core's per-endpoint DMA request lines. One endpoint is granted
//   at a time for at most BURST_LEN words. Each word-ack from the channel is
//   forwarded to the core as a registered one-hot pulse on dma_ack_o. A stall
//   timeout frees the channel when it stops responding.
//
//   Optional feature macro: USBF_DMA_SCHED_PRIO_EN
//     defined   : endpoints in prio_mask_i that are requesting win arbitration
//                 over all others (round-robin within that set)
//     undefined : prio_mask_i is ignored, plain round-robin over dma_req_i
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   en_i         scheduler enable; low blocks new grants only
//   dma_req_i    per-endpoint level requests from the core
//   dma_ack_o    one-hot, one-cycle word-ack pulses to the core
//   prio_mask_i  high-priority endpoint set (priority build only)
//   ch_req_o     request to the DMA channel
//   ch_ep_o      endpoint index of the current grant
//   ch_gnt_i     channel accepted the request
//   ch_ack_i     channel moved one word (one-cycle pulse)
//   busy_o       scheduler not idle (debug view of the FSM)
//   to_err_o     one-cycle pulse on stall timeout
//   to_ep_o      endpoint of the last timeout, held until the next one
//
// Channel handshake: ch_req_o is a level held from arbitration until
// release. ch_gnt_i is honoured only while waiting for the grant (REQ);
// ch_ack_i is honoured only after the grant (XFER), one word per cycle it is
// high. Both are ignored in any other state.
// ---------------------------------------------------------------------------
module usbf_dma_sched #(
  parameter int unsigned NUM_EP    = 16,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] dma_req_i,
  output logic [15:0] dma_ack_o,
  input  logic [15:0] prio_mask_i,
  output logic        ch_req_o,
  output logic [3:0]  ch_ep_o,
  input  logic        ch_gnt_i,
  input  logic        ch_ack_i,
  output logic        busy_o,
  output logic        to_err_o,
  output logic [3:0]  to_ep_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_REL  = 2'd3
  } state_t;

  localparam logic [15:0] EP_MASK = (NUM_EP >= 16) ? 16'hFFFF
                                                   : 16'((32'd1 << NUM_EP) - 32'd1);
  localparam logic [7:0]  BURST_W = 8'(BURST_LEN);
  localparam logic [7:0]  TO_W    = 8'(TO_CYCLES);
  localparam logic [3:0]  LAST_EP = 4'(NUM_EP - 1);
  localparam logic [4:0]  NUM_W   = 5'(NUM_EP);

  state_t      state;
  logic [3:0]  ptr;
  logic [3:0]  cur_ep;
  logic [7:0]  wcnt;
  logic [7:0]  tcnt;

  logic [15:0] req_v;
  logic [15:0] cand;
  logic        pick_vld;
  logic [3:0]  pick_ep;
  logic [4:0]  idx;
  logic [7:0]  wcnt_inc;
  logic [7:0]  tcnt_inc;
  logic        cur_req;
  logic        stall_to;

  // Requests from endpoints beyond NUM_EP never take part in arbitration.
  assign req_v = dma_req_i & EP_MASK;

`ifdef USBF_DMA_SCHED_PRIO_EN
  logic [15:0] hi_v;
  assign hi_v = req_v & prio_mask_i;
  assign cand = (|hi_v) ? hi_v : req_v;
`else
  logic unused_prio;
  assign unused_prio = ^prio_mask_i;
  assign cand        = req_v;
`endif

  // First candidate at or after ptr, wrapping at NUM_EP.
  always_comb begin
    pick_vld = 1'b0;
    pick_ep  = 4'd0;
    idx      = 5'd0;
    for (int i = 0; i < NUM_EP; i++) begin
      idx = 5'(ptr) + 5'(i);
      if (idx >= NUM_W) idx = idx - NUM_W;
      if (!pick_vld && cand[idx[3:0]]) begin
        pick_vld = 1'b1;
        pick_ep  = idx[3:0];
      end
    end
  end

  assign cur_req  = dma_req_i[cur_ep];
  // Both counters saturate instead of wrapping.
  assign wcnt_inc = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
  assign tcnt_inc = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;
  assign stall_to = (TO_CYCLES != 0) && (tcnt_inc == TO_W);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      ptr       <= 4'd0;
      cur_ep    <= 4'd0;
      wcnt      <= 8'd0;
      tcnt      <= 8'd0;
      dma_ack_o <= 16'd0;
      ch_req_o  <= 1'b0;
      ch_ep_o   <= 4'd0;
      busy_o    <= 1'b0;
      to_err_o  <= 1'b0;
      to_ep_o   <= 4'd0;
    end else begin
      dma_ack_o <= 16'd0;
      to_err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en_i && pick_vld) begin
            cur_ep   <= pick_ep;
            ch_ep_o  <= pick_ep;
            ch_req_o <= 1'b1;
            wcnt     <= 8'd0;
            tcnt     <= 8'd0;
            busy_o   <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (ch_gnt_i) begin
            wcnt  <= 8'd0;
            tcnt  <= 8'd0;
            state <= S_XFER;
          end else if (!cur_req) begin
            ch_req_o <= 1'b0;
            state    <= S_REL;
          end else if (stall_to) begin
            to_err_o <= 1'b1;
            to_ep_o  <= cur_ep;
            ch_req_o <= 1'b0;
            state    <= S_REL;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        S_XFER: begin
          if (ch_ack_i) begin
            // The word is always forwarded, even when the core drops its
            // request in the same cycle.
            dma_ack_o <= 16'h0001 << cur_ep;
            wcnt      <= wcnt_inc;
            tcnt      <= 8'd0;
            if (wcnt_inc == BURST_W || !cur_req) begin
              ch_req_o <= 1'b0;
              state    <= S_REL;
            end
          end else if (!cur_req) begin
            ch_req_o <= 1'b0;
            state    <= S_REL;
          end else if (stall_to) begin
            to_err_o <= 1'b1;
            to_ep_o  <= cur_ep;
            ch_req_o <= 1'b0;
            state    <= S_REL;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        S_REL: begin
          ptr    <= (cur_ep == LAST_EP) ? 4'd0 : cur_ep + 4'd1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usbf_dma_sched.sv
// ---------------------------------------------------------------------------
// tb_usbf_dma_sched
//   Self-checking bench for usbf_dma_sched (NUM_EP=16, BURST_LEN=4,
//   TO_CYCLES=8). Directed scenarios plus a randomized burst loop checked
//   against a grant-level model: the next endpoint is the first requester at
//   or after a pointer that moves past each released endpoint, and a burst
//   forwards min(words offered, BURST_LEN) acks.
// ---------------------------------------------------------------------------
module tb_usbf_dma_sched;

  localparam int BURST_LEN = 4;
  localparam int TO_CYCLES = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [15:0] dma_req_i;
  logic [15:0] dma_ack_o;
  logic [15:0] prio_mask_i;
  logic        ch_req_o;
  logic [3:0]  ch_ep_o;
  logic        ch_gnt_i;
  logic        ch_ack_i;
  logic        busy_o;
  logic        to_err_o;
  logic [3:0]  to_ep_o;

  always #5 clk = ~clk;

  usbf_dma_sched #(
    .NUM_EP    (16),
    .BURST_LEN (BURST_LEN),
    .TO_CYCLES (TO_CYCLES)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .dma_req_i   (dma_req_i),
    .dma_ack_o   (dma_ack_o),
    .prio_mask_i (prio_mask_i),
    .ch_req_o    (ch_req_o),
    .ch_ep_o     (ch_ep_o),
    .ch_gnt_i    (ch_gnt_i),
    .ch_ack_i    (ch_ack_i),
    .busy_o      (busy_o),
    .to_err_o    (to_err_o),
    .to_ep_o     (to_ep_o)
  );

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  // ---------------- reference model ----------------
  function automatic int model_pick(input logic [15:0] req, input logic [15:0] prio,
                                    input int ptr);
    logic [15:0] set;
    set = req;
`ifdef USBF_DMA_SCHED_PRIO_EN
    if ((req & prio) != 16'd0) set = req & prio;
`endif
    for (int i = 0; i < 16; i++)
      if (set[(ptr + i) % 16]) return (ptr + i) % 16;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (!ch_req_o && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Grant after gnt_dly cycles, then ack every cycle until the scheduler
  // releases the channel.
  task automatic burst_full(input int gnt_dly, output int acks, output logic [15:0] ack_or);
    acks   = 0;
    ack_or = 16'd0;
    repeat (gnt_dly) tick();
    ch_gnt_i = 1'b1;
    tick();
    ch_gnt_i = 1'b0;
    for (int c = 0; c < 40 && ch_req_o; c++) begin
      ch_ack_i = 1'b1;
      tick();
      if (dma_ack_o != 16'd0) begin
        acks++;
        ack_or |= dma_ack_o;
      end
    end
    ch_ack_i = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_ptr = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL reset_ch_req: got %0b want 0", ch_req_o); end
    checks++; if (ch_ep_o !== 4'd0) begin errors++; $display("FAIL reset_ch_ep: got %0d want 0", ch_ep_o); end
    checks++; if (dma_ack_o !== 16'd0) begin errors++; $display("FAIL reset_dma_ack: got %h want 0", dma_ack_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    checks++; if (to_err_o !== 1'b0) begin errors++; $display("FAIL reset_to_err: got %0b want 0", to_err_o); end
    checks++; if (to_ep_o !== 4'd0) begin errors++; $display("FAIL reset_to_ep: got %0d want 0", to_ep_o); end
    rst_i = 1'b0;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_single_burst();
    int lat, acks, exp_ep;
    logic [15:0] ack_or;
    dma_req_i = 16'h0008;
    exp_ep = model_pick(dma_req_i, prio_mask_i, m_ptr);
    wait_req(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency: got %0d want 1", lat); end
    checks++; if (ch_ep_o !== 4'(exp_ep)) begin errors++; $display("FAIL single_ep: got %0d want %0d", ch_ep_o, exp_ep); end
    burst_full(1, acks, ack_or);
    dma_req_i = 16'h0000;
    checks++; if (acks !== BURST_LEN) begin errors++; $display("FAIL single_acks: got %0d want %0d", acks, BURST_LEN); end
    checks++; if (ack_or !== 16'h0008) begin errors++; $display("FAIL single_ack_ep: got %h want 0008", ack_or); end
    checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL single_release: got %0b want 0", ch_req_o); end
    m_ptr = (exp_ep + 1) % 16;
    tick();
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b want 0", busy_o); end
    // Pointer must now sit past ep3: with ep3 and ep5 both requesting, ep5 wins.
    dma_req_i = 16'h0028;
    exp_ep = model_pick(dma_req_i, prio_mask_i, m_ptr);
    wait_req(lat);
    checks++; if (ch_ep_o !== 4'(exp_ep)) begin errors++; $display("FAIL single_ptr_next: got %0d want %0d", ch_ep_o, exp_ep); end
    dma_req_i = 16'h0000;
    tick();
    checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL single_drop_in_req: got %0b want 0", ch_req_o); end
    m_ptr = (exp_ep + 1) % 16;
    tick();
    tick();
  endtask

  task automatic test_fairness();
    int lat, acks, exp_ep;
    logic [15:0] ack_or;
    pulse_reset();
    dma_req_i = 16'h0222;
    for (int g = 0; g < 6; g++) begin
      exp_ep = model_pick(dma_req_i, prio_mask_i, m_ptr);
      wait_req(lat);
      if (g == 0) begin
        checks++; if (lat !== 1) begin errors++; $display("FAIL fair_latency: got %0d want 1", lat); end
      end else begin
        checks++; if (lat < 2 || !ch_req_o) begin errors++; $display("FAIL fair_gap: got %0d low cycles want >=2 then req", lat); end
      end
      checks++; if (ch_ep_o !== 4'(exp_ep)) begin errors++; $display("FAIL fair_ep%0d: got %0d want %0d", g, ch_ep_o, exp_ep); end
      burst_full(0, acks, ack_or);
      checks++; if (acks !== BURST_LEN || ack_or !== (16'h1 << exp_ep)) begin
        errors++; $display("FAIL fair_acks%0d: got %0d acks on %h want %0d on ep%0d", g, acks, ack_or, BURST_LEN, exp_ep);
      end
      m_ptr = (exp_ep + 1) % 16;
    end
    dma_req_i = 16'h0000;
    tick();
    tick();
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fair_idle: got %0b want 0", busy_o); end
  endtask

  task automatic test_early_drop();
    int lat, acks, exp_ep;
    acks = 0;
    dma_req_i = 16'h0004;
    exp_ep = model_pick(dma_req_i, prio_mask_i, m_ptr);
    wait_req(lat);
    checks++; if (ch_ep_o !== 4'(exp_ep)) begin errors++; $display("FAIL drop_ep: got %0d want %0d", ch_ep_o, exp_ep); end
    ch_gnt_i = 1'b1;
    tick();
    ch_gnt_i = 1'b0;
    repeat (2) begin
      ch_ack_i = 1'b1;
      tick();
      if (dma_ack_o == 16'h0004) acks++;
    end
    ch_ack_i  = 1'b0;
    dma_req_i = 16'h0000;
    tick();
    checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL drop_release: got %0b want 0", ch_req_o); end
    repeat (3) begin
      if (dma_ack_o != 16'd0) acks++;
      tick();
    end
    checks++; if (acks !== 2) begin errors++; $display("FAIL drop_acks: got %0d want 2", acks); end
    m_ptr = (exp_ep + 1) % 16;
  endtask

  task automatic test_timeout();
    int lat, n, exp_ep;
    dma_req_i = 16'h0080;
    exp_ep = model_pick(dma_req_i, prio_mask_i, m_ptr);
    wait_req(lat);
    checks++; if (ch_ep_o !== 4'(exp_ep)) begin errors++; $display("FAIL to_grant_ep: got %0d want %0d", ch_ep_o, exp_ep); end
    ch_gnt_i = 1'b1;
    tick();
    ch_gnt_i = 1'b0;
    n = 0;
    while (!to_err_o && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n !== TO_CYCLES) begin errors++; $display("FAIL to_delay: got %0d cycles want %0d", n, TO_CYCLES); end
    checks++; if (to_ep_o !== 4'(exp_ep)) begin errors++; $display("FAIL to_ep: got %0d want %0d", to_ep_o, exp_ep); end
    checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL to_release: got %0b want 0", ch_req_o); end
    m_ptr = (exp_ep + 1) % 16;
    tick();
    checks++; if (to_err_o !== 1'b0 || to_ep_o !== 4'(exp_ep)) begin
      errors++; $display("FAIL to_pulse_hold: got err=%0b ep=%0d want err=0 ep=%0d", to_err_o, to_ep_o, exp_ep);
    end
    exp_ep = model_pick(dma_req_i, prio_mask_i, m_ptr);
    wait_req(lat);
    checks++; if (!ch_req_o || ch_ep_o !== 4'(exp_ep)) begin
      errors++; $display("FAIL to_regrant: got req=%0b ep=%0d want req=1 ep=%0d", ch_req_o, ch_ep_o, exp_ep);
    end
    dma_req_i = 16'h0000;
    tick();
    m_ptr = (exp_ep + 1) % 16;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_xfer();
    int lat, late, exp_ep;
    late = 0;
    dma_req_i = 16'h0200;
    wait_req(lat);
    ch_gnt_i = 1'b1;
    tick();
    ch_gnt_i = 1'b0;
    ch_ack_i = 1'b1;
    tick();
    checks++; if (dma_ack_o !== 16'h0200) begin errors++; $display("FAIL rst_first_ack: got %h want 0200", dma_ack_o); end
    // Ack still offered during reset: it must be dropped.
    rst_i     = 1'b1;
    dma_req_i = 16'h0000;
    tick();
    rst_i    = 1'b0;
    ch_ack_i = 1'b0;
    m_ptr    = 0;
    checks++; if (ch_req_o !== 1'b0 || ch_ep_o !== 4'd0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got req=%0b ep=%0d busy=%0b want 0 0 0", ch_req_o, ch_ep_o, busy_o);
    end
    checks++; if (dma_ack_o !== 16'd0 || to_err_o !== 1'b0 || to_ep_o !== 4'd0) begin
      errors++; $display("FAIL rst_mid_out: got ack=%h err=%0b to_ep=%0d want 0 0 0", dma_ack_o, to_err_o, to_ep_o);
    end
    repeat (3) begin
      tick();
      if (dma_ack_o != 16'd0 || ch_req_o) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles want 0", late); end
    dma_req_i = 16'h0204;
    exp_ep = model_pick(dma_req_i, prio_mask_i, m_ptr);
    wait_req(lat);
    checks++; if (ch_ep_o !== 4'(exp_ep)) begin errors++; $display("FAIL rst_ptr_zero: got %0d want %0d", ch_ep_o, exp_ep); end
    dma_req_i = 16'h0000;
    tick();
    m_ptr = (exp_ep + 1) % 16;
    tick();
    tick();
  endtask

  task automatic test_priority();
    int lat, acks, exp_ep;
    logic [15:0] ack_or;
    pulse_reset();
    prio_mask_i = 16'h8000;
    dma_req_i   = 16'h8002;
    for (int g = 0; g < 2; g++) begin
      exp_ep = model_pick(dma_req_i, prio_mask_i, m_ptr);
      wait_req(lat);
      checks++; if (ch_ep_o !== 4'(exp_ep)) begin errors++; $display("FAIL prio_ep%0d: got %0d want %0d", g, ch_ep_o, exp_ep); end
      burst_full(0, acks, ack_or);
      m_ptr = (exp_ep + 1) % 16;
    end
    dma_req_i   = 16'h0000;
    prio_mask_i = 16'h0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_enable();
    int lat, acks, exp_ep;
    logic [15:0] ack_or;
    en_i      = 1'b0;
    dma_req_i = 16'h0010;
    repeat (4) tick();
    checks++; if (ch_req_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL en_block: got req=%0b busy=%0b want 0 0", ch_req_o, busy_o);
    end
    en_i = 1'b1;
    exp_ep = model_pick(dma_req_i, prio_mask_i, m_ptr);
    wait_req(lat);
    checks++; if (lat !== 1 || ch_ep_o !== 4'(exp_ep)) begin
      errors++; $display("FAIL en_grant: got lat=%0d ep=%0d want 1 %0d", lat, ch_ep_o, exp_ep);
    end
    en_i = 1'b0;
    burst_full(0, acks, ack_or);
    checks++; if (acks !== BURST_LEN) begin errors++; $display("FAIL en_mid_burst: got %0d acks want %0d", acks, BURST_LEN); end
    m_ptr = (exp_ep + 1) % 16;
    repeat (4) tick();
    checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL en_no_regrant: got %0b want 0", ch_req_o); end
    dma_req_i = 16'h0000;
    en_i      = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      logic [15:0] req;
      logic [15:0] prio;
      int k, gdly, gap, exp_ep, exp_acks, lat, given, wait_n, acks, cyc;
      bit dwa, dropped;
      req  = 16'($urandom_range(1, 65535));
      prio = 16'($urandom);
      k    = $urandom_range(0, 6);
      gdly = $urandom_range(0, 3);
      gap  = $urandom_range(0, 2);
      dwa  = 1'($urandom_range(0, 1));
      exp_ep   = model_pick(req, prio, m_ptr);
      exp_acks = (k < BURST_LEN) ? k : BURST_LEN;
      prio_mask_i = prio;
      dma_req_i   = req;
      acks = 0;
      cyc  = 0;
      wait_req(lat);
      checks++; if (lat !== 1 || ch_ep_o !== 4'(exp_ep)) begin
        errors++; $display("FAIL rnd%0d_grant: got lat=%0d ep=%0d want 1 %0d (req=%h)", it, lat, ch_ep_o, exp_ep, req);
      end
      if (k == 0) begin
        dma_req_i = 16'h0000;
        tick();
        checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_drop_req: got %0b want 0", it, ch_req_o); end
      end else begin
        repeat (gdly) tick();
        ch_gnt_i = 1'b1;
        tick();
        ch_gnt_i = 1'b0;
        en_i     = 1'($urandom_range(0, 1));
        given    = 0;
        wait_n   = gap;
        while (ch_req_o && cyc < 80) begin
          dropped = 1'b0;
          if (given < k) begin
            if (wait_n == 0) begin
              ch_ack_i = 1'b1;
              given++;
              wait_n = gap;
              if (given == k && dwa) begin
                dma_req_i = 16'h0000;
                dropped   = 1'b1;
              end
            end else begin
              wait_n--;
            end
          end else begin
            dma_req_i = 16'h0000;
            dropped   = 1'b1;
          end
          tick();
          cyc++;
          ch_ack_i = 1'b0;
          if (dma_ack_o != 16'd0) begin
            acks++;
            checks++; if (dma_ack_o !== (16'h0001 << exp_ep)) begin
              errors++; $display("FAIL rnd%0d_ack_ep: got %h want ep%0d", it, dma_ack_o, exp_ep);
            end
          end
          if (dropped) begin
            checks++; if (ch_req_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_release: got %0b want 0", it, ch_req_o); end
          end
        end
      end
      dma_req_i = 16'h0000;
      ch_ack_i  = 1'b0;
      checks++; if (ch_req_o !== 1'b0 || acks !== exp_acks) begin
        errors++; $display("FAIL rnd%0d_burst: got req=%0b acks=%0d want 0 %0d", it, ch_req_o, acks, exp_acks);
      end
      m_ptr = (exp_ep + 1) % 16;
      tick();
      checks++; if (dma_ack_o !== 16'd0) begin errors++; $display("FAIL rnd%0d_stray_ack: got %h want 0", it, dma_ack_o); end
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: got %0b want 0", it, busy_o); end
      en_i = 1'b1;
    end
    prio_mask_i = 16'h0000;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_i       = 1'b1;
    en_i        = 1'b1;
    dma_req_i   = 16'h0000;
    prio_mask_i = 16'h0000;
    ch_gnt_i    = 1'b0;
    ch_ack_i    = 1'b0;
    test_reset();
    test_single_burst();
    test_fairness();
    test_early_drop();
    test_timeout();
    test_reset_mid_xfer();
    test_priority();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
